// File: rtl/stepper_seq_ctrl.sv
// Unipolar stepper phase sequencer: wave / full / half-step drive, step-rate
// prescaler, counted or continuous moves, start/busy/done handshake and a
// wrapping signed position counter.
module stepper_seq_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] period,
    input  logic [CNT_W-1:0] nsteps,
    input  logic             cont,
    input  logic             abort,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             step_pulse,
    output logic [3:0]       coils,
    output logic [POS_W-1:0] position
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [DIV_W-1:0] presc, presc_n;
    logic [DIV_W-1:0] period_r, period_n;
    logic [CNT_W-1:0] remaining, rem_n;
    logic [POS_W-1:0] pos_n;
    logic             half_r, half_n;
    logic             dir_r, dir_n;
    logic             cont_r, cont_n;
    logic             tick;
    logic [2:0]       step_amt;
    logic [3:0]       coils_n;

    // Coil pattern for each of the eight half-step positions
    function automatic logic [3:0] phase(input logic [2:0] i);
        case (i)
            3'd0:    phase = 4'b0001;
            3'd1:    phase = 4'b0011;
            3'd2:    phase = 4'b0010;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0100;
            3'd5:    phase = 4'b1100;
            3'd6:    phase = 4'b1000;
            default: phase = 4'b1001;
        endcase
    endfunction

    assign step_amt = half_r ? 3'd1 : 3'd2;

    // Next-state, run bookkeeping and registered-output values
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        presc_n  = presc;
        period_n = period_r;
        rem_n    = remaining;
        pos_n    = position;
        half_n   = half_r;
        dir_n    = dir_r;
        cont_n   = cont_r;
        tick     = 1'b0;
        case (state)
            IDLE: begin
                if (en && start) begin
                    state_n  = RUN;
                    // Move parameters are frozen here for the whole run
                    period_n = (period == '0) ? DIV_ONE : period;
                    presc_n  = (period == '0) ? DIV_ONE : period;
                    rem_n    = nsteps;
                    half_n   = mode[1];
                    dir_n    = dir;
                    cont_n   = cont;
                    // Align idx to the mode's phase family so the run's coil
                    // patterns stay on even (wave) or odd (full) entries
                    if (mode == 2'b00)      idx_n = {idx[2:1], 1'b0};
                    else if (mode == 2'b01) idx_n = {idx[2:1], 1'b1};
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (!cont_r && remaining == '0) begin
                    // Zero-length counted move: finish without stepping
                    state_n = IDLE;
                end else begin
                    if (presc == DIV_ONE) begin
                        tick    = 1'b1;
                        presc_n = period_r;
                    end else begin
                        presc_n = presc - DIV_ONE;
                    end
                    if (tick) begin
                        idx_n = dir_r ? idx - step_amt : idx + step_amt;
                        pos_n = dir_r ? position - POS_ONE : position + POS_ONE;
                        if (!cont_r) begin
                            rem_n = remaining - CNT_ONE;
                            if (remaining == CNT_ONE) state_n = IDLE;
                        end
                    end
                    // A step due on the same edge as abort is still taken
                    if (abort) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        coils_n = (en && (state_n == RUN || hold)) ? phase(idx_n) : 4'b0000;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            presc      <= '0;
            period_r   <= '0;
            remaining  <= '0;
            position   <= '0;
            half_r     <= 1'b0;
            dir_r      <= 1'b0;
            cont_r     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_pulse <= 1'b0;
            coils      <= 4'b0000;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            presc      <= presc_n;
            period_r   <= period_n;
            remaining  <= rem_n;
            position   <= pos_n;
            half_r     <= half_n;
            dir_r      <= dir_n;
            cont_r     <= cont_n;
            busy       <= (state_n == RUN);
            done       <= (state == RUN) && (state_n == IDLE);
            step_pulse <= tick;
            coils      <= coils_n;
        end
    end

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed bench for stepper_seq_ctrl: drive modes, timing, abort, en drop,
// async reset and 4-bit position wrap (second instance with POS_W=4).
module tb_stepper_seq_ctrl;

    logic        clk, rst, en, start, dir, cont, abort, hold;
    logic [1:0]  mode;
    logic [15:0] period, nsteps;
    logic        busy, done, step_pulse;
    logic [3:0]  coils;
    logic signed [23:0] position;
    logic        busy2, done2, step2;
    logic [3:0]  coils2;
    logic signed [3:0] pos4;

    int n_chk = 0, n_pass = 0;
    int step_cnt = 0, done_cnt = 0;
    int s0, d0, n;

    logic [3:0] full_exp [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
    logic [3:0] half_exp [8] = '{4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                 4'b0110, 4'b0010, 4'b0011, 4'b0001};

    stepper_seq_ctrl #(.DIV_W(16), .CNT_W(16), .POS_W(24)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
        .period(period), .nsteps(nsteps), .cont(cont), .abort(abort), .hold(hold),
        .busy(busy), .done(done), .step_pulse(step_pulse), .coils(coils),
        .position(position)
    );

    stepper_seq_ctrl #(.DIV_W(16), .CNT_W(16), .POS_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .dir(dir),
        .period(period), .nsteps(nsteps), .cont(cont), .abort(abort), .hold(hold),
        .busy(busy2), .done(done2), .step_pulse(step2), .coils(coils2),
        .position(pos4)
    );

    always #5 clk = ~clk;

    // Count pulses once per cycle, away from the active edge
    always @(negedge clk) begin
        if (step_pulse) step_cnt++;
        if (done)       done_cnt++;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        clk = 0; rst = 1; en = 0; start = 0; mode = 0; dir = 0; period = 0;
        nsteps = 0; cont = 0; abort = 0; hold = 0;
        #12;
        chk("rst_coils", coils, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_pos", position, 0);
        @(negedge clk); rst = 0;
        tick();

        // 1: full mode forward, period 4, 4 steps
        en = 1; mode = 2'b01; dir = 0; period = 4; nsteps = 4; hold = 1;
        do_start();
        chk("t1_busy", busy, 1);
        chk("t1_coils0", coils, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            repeat (3) tick();
            chk("t1_nopulse", step_pulse, 0);
            tick();
            chk("t1_pulse", step_pulse, 1);
            chk("t1_coils", coils, full_exp[k]);
        end
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_pos", position, 4);
        tick();
        chk("t1_done_off", done, 0);

        // 2: half step reverse, period 1, 8 steps from idx 0
        rst = 1; #2; rst = 0;
        mode = 2'b10; dir = 1; period = 1; nsteps = 8;
        do_start();
        chk("t2_coils0", coils, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_pulse", step_pulse, 1);
            chk("t2_coils", coils, half_exp[k]);
        end
        chk("t2_done", done, 1);
        chk("t2_pos", position, -8);

        // 3: wave continuous, period 2, abort after 5 steps
        tick();
        mode = 2'b00; dir = 0; cont = 1; period = 2; hold = 1;
        s0 = step_cnt; d0 = done_cnt;
        do_start();
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            tick();
            if (step_pulse) n++;
        end
        abort = 1;
        tick();
        abort = 0;
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        repeat (3) tick();
        chk("t3_steps", step_cnt - s0, 5);
        chk("t3_dones", done_cnt - d0, 1);
        chk("t3_hold", coils, 4'b0010);
        chk("t3_pos", position, -3);
        hold = 0;
        tick();
        chk("t3_nohold", coils, 4'b0000);

        // 4: zero-length counted move
        mode = 2'b10; cont = 0; nsteps = 0; hold = 1;
        tick();
        s0 = step_cnt; d0 = done_cnt;
        do_start();
        chk("t4_busy", busy, 1);
        chk("t4_done_early", done, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_busy_end", busy, 0);
        chk("t4_coils", coils, 4'b0010);
        tick();
        chk("t4_nostep", step_cnt - s0, 0);
        chk("t4_dones", done_cnt - d0, 1);

        // 5: en dropped mid-run, start while busy and start with en low
        mode = 2'b01; period = 3; nsteps = 10;
        do_start();
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("t5_pulse", step_pulse, 1);
        chk("t5_coils", coils, 4'b1100);
        en = 0;
        tick();
        chk("t5_coils_off", coils, 4'b0000);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_pos", position, -2);
        do_start();
        tick();
        chk("t5_en0_busy", busy, 0);
        chk("t5_en0_coils", coils, 4'b0000);

        // 6: async reset mid-run, no done afterwards
        en = 1; mode = 2'b10; period = 5; nsteps = 10; hold = 0;
        do_start();
        chk("t6_coils_run", coils, 4'b1100);
        tick(); tick();
        d0 = done_cnt;
        #2 rst = 1;
        #1;
        chk("t6_rst_coils", coils, 4'b0000);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pos", position, 0);
        @(negedge clk); rst = 0;
        repeat (3) tick();
        chk("t6_no_done", done_cnt - d0, 0);

        // 6b: 4-bit position wraps 7 -> -8
        mode = 2'b01; dir = 0; period = 1; nsteps = 9; hold = 1;
        do_start();
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("t6_wrap", pos4, (i < 8) ? i : i - 16);
        end
        chk("t6_wrap_done", done2, 1);
        chk("t6_pos24", position, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
